// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver, DBIT data bits LSB first, optional parity, SB_TICK stop ticks.
// Frames are reported as a registered word plus error flags that hold until the next frame completes.
module uart_rx_os #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t          r_state;
    logic [1:0]      r_sync;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic            r_p;
    logic            w_rx;
    assign w_rx = r_sync[1];
    assign busy = (r_state != IDLE);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sync       <= 2'b11;
            r_s          <= '0;
            r_n          <= '0;
            r_b          <= '0;
            r_p          <= 1'b0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], rx};
            rx_done_tick <= 1'b0;
            case (r_state)
                IDLE: if (!w_rx) begin
                    r_state <= START;
                    r_s     <= '0;
                end
                // mid-start re-check rejects glitches shorter than half a bit
                START: if (s_tick) begin
                    if (r_s == SW'(7)) begin
                        r_state <= w_rx ? IDLE : DATA;
                        r_s     <= '0;
                        r_n     <= '0;
                    end else r_s <= r_s + 1'b1;
                end
                DATA: if (s_tick) begin
                    if (r_s == SW'(15)) begin
                        r_s <= '0;
                        r_b <= {w_rx, r_b[DBIT-1:1]};
                        if (r_n == NW'(DBIT-1)) r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        else r_n <= r_n + 1'b1;
                    end else r_s <= r_s + 1'b1;
                end
                PARITY: if (s_tick) begin
                    if (r_s == SW'(15)) begin
                        r_s     <= '0;
                        r_p     <= w_rx;
                        r_state <= STOP;
                    end else r_s <= r_s + 1'b1;
                end
                STOP: if (s_tick) begin
                    if (r_s == SW'(SB_TICK-1)) begin
                        r_state      <= IDLE;
                        dout         <= r_b;
                        frame_err    <= ~w_rx;
                        parity_err   <= (PARITY_EN != 0) && ((^r_b ^ r_p) != 1'(PARITY_ODD));
                        rx_done_tick <= 1'b1;
                    end else r_s <= r_s + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
